// File: rtl/vreg_port_arbiter.sv
// vreg_port_arbiter: round-robin sharing of one vector-register bank port.
// Optional build macro VREG_ARB_WRITE_PRIORITY_EN favours writes over reads.
module vreg_port_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter int VECTOR_REG_WIDTH  = 64,
    parameter int NUM_OF_VECTOR_REG = 32,
    parameter int MAX_OUTSTANDING   = 4,
    localparam int RW = $clog2(NUM_OF_VECTOR_REG)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_REQ-1:0]                    req_vld,
    input  logic [NUM_REQ-1:0]                    req_we,
    input  logic [NUM_REQ*RW-1:0]                 req_reg,
    input  logic [NUM_REQ*VECTOR_REG_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]                    req_grant,
    output logic [NUM_REQ-1:0]                    rsp_vld,
    output logic [NUM_REQ*VECTOR_REG_WIDTH-1:0]   rsp_data,
    output logic                                  bank_req_vld,
    output logic                                  bank_we,
    output logic [RW-1:0]                         bank_reg,
    output logic [VECTOR_REG_WIDTH-1:0]           bank_wdata,
    input  logic                                  bank_busy,
    input  logic                                  bank_rsp_vld,
    input  logic [VECTOR_REG_WIDTH-1:0]           bank_rsp_data,
    input  logic                                  drain,
    output logic                                  idle,
    output logic                                  err_unexp_rsp
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = AW + 1;
    localparam int W  = VECTOR_REG_WIDTH;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef enum logic {
        RUN,
        DRAIN
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   win;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_d;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [PW-1:0]   tags [MAX_OUTSTANDING];
    logic [PW-1:0]   head;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] cand;
    logic            found;
    logic            issue;
    logic            push;
    logic            pop;
    logic            rd_ok;
    logic            sel_we;
    logic [RW-1:0]   sel_reg;
    logic [W-1:0]    sel_wdata;

    assign head  = tags[rd_ptr];
    assign pop   = bank_rsp_vld && (count != '0);
    assign rd_ok = (count != MAX_CNT) || pop;

    // Candidate masking and round-robin winner search starting at rr_ptr
    always_comb begin
        int idx;
        logic [PW-1:0] pos;
        idx   = 0;
        pos   = '0;
        found = 1'b0;
        win   = '0;
        elig  = req_vld & ~req_grant;
        if (!rd_ok) begin
            elig = elig & req_we;
        end
        cand = elig;
`ifdef VREG_ARB_WRITE_PRIORITY_EN
        if (|(elig & req_we)) begin
            cand = elig & req_we;
        end
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            pos = PW'(idx);
            if (!found && cand[pos]) begin
                found = 1'b1;
                win   = pos;
            end
        end
    end

    // Select the winner's access fields and derive issue/push/count
    always_comb begin
        sel_we    = 1'b0;
        sel_reg   = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == PW'(i)) begin
                sel_we    = req_we[i];
                sel_reg   = req_reg[i*RW +: RW];
                sel_wdata = req_wdata[i*W +: W];
            end
        end
        issue   = found && !bank_busy && (state_q == RUN);
        push    = issue && !sel_we;
        count_d = count;
        if (push && !pop) begin
            count_d = count + 1'b1;
        end else if (!push && pop) begin
            count_d = count - 1'b1;
        end
    end

    // Next-state logic for the run/drain mode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:   if (drain)  state_d = DRAIN;
            DRAIN: if (!drain) state_d = RUN;
        endcase
    end

    // Mode, pointer, occupancy, idle and sticky error registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            rr_ptr        <= '0;
            count         <= '0;
            idle          <= 1'b0;
            err_unexp_rsp <= 1'b0;
        end else begin
            state_q <= state_d;
            count   <= count_d;
            idle    <= (state_d == DRAIN) && (count_d == '0);
            if (issue) begin
                rr_ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
            end
            if (bank_rsp_vld && (count == '0)) begin
                err_unexp_rsp <= 1'b1;
            end
        end
    end

    // Registered bank access and one-cycle grant pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_grant    <= '0;
            bank_req_vld <= 1'b0;
            bank_we      <= 1'b0;
            bank_reg     <= '0;
            bank_wdata   <= '0;
        end else begin
            req_grant    <= issue ? (NUM_REQ'(1) << win) : '0;
            bank_req_vld <= issue;
            bank_we      <= issue && sel_we;
            if (issue) begin
                bank_reg   <= sel_reg;
                bank_wdata <= sel_wdata;
            end
        end
    end

    // In-order tag FIFO of requesters with reads in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tags[i] <= '0;
            end
        end else begin
            if (push) begin
                tags[wr_ptr] <= win;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Route returning read data to the requester at the FIFO head
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_vld  <= '0;
            rsp_data <= '0;
        end else begin
            rsp_vld <= pop ? (NUM_REQ'(1) << head) : '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pop && (head == PW'(i))) begin
                    rsp_data[i*W +: W] <= bank_rsp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_vreg_port_arbiter.sv
// tb_vreg_port_arbiter: directed checks of arbitration, FIFO, stall,
// drain, priority, unexpected response and asynchronous reset.
module tb_vreg_port_arbiter;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int RW = 5;
`ifdef VREG_ARB_WRITE_PRIORITY_EN
    localparam int FIRST  = 3;
    localparam int SECOND = 0;
`else
    localparam int FIRST  = 0;
    localparam int SECOND = 3;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_vld;
    logic [N-1:0]     req_we;
    logic [N*RW-1:0]  req_reg;
    logic [N*W-1:0]   req_wdata;
    logic [N-1:0]     req_grant;
    logic [N-1:0]     rsp_vld;
    logic [N*W-1:0]   rsp_data;
    logic             bank_req_vld;
    logic             bank_we;
    logic [RW-1:0]    bank_reg;
    logic [W-1:0]     bank_wdata;
    logic             bank_busy;
    logic             bank_rsp_vld;
    logic [W-1:0]     bank_rsp_data;
    logic             drain;
    logic             idle;
    logic             err_unexp_rsp;

    int checks   = 0;
    int failures = 0;

    logic [RW-1:0] rg [N];
    logic [W-1:0]  wd [N];

    int            due_q [$];
    logic [RW-1:0] reg_q [$];
    int            exp_g;
    int            exp_r;
    int            nrsp;
    logic          rsp_prev;

    vreg_port_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req_vld       (req_vld),
        .req_we        (req_we),
        .req_reg       (req_reg),
        .req_wdata     (req_wdata),
        .req_grant     (req_grant),
        .rsp_vld       (rsp_vld),
        .rsp_data      (rsp_data),
        .bank_req_vld  (bank_req_vld),
        .bank_we       (bank_we),
        .bank_reg      (bank_reg),
        .bank_wdata    (bank_wdata),
        .bank_busy     (bank_busy),
        .bank_rsp_vld  (bank_rsp_vld),
        .bank_rsp_data (bank_rsp_data),
        .drain         (drain),
        .idle          (idle),
        .err_unexp_rsp (err_unexp_rsp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [N*W-1:0] obs,
                       input logic [N*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    function automatic logic [W-1:0] fdat(input logic [RW-1:0] r);
        return 64'hC0DE_0000_0000_0000 | W'(r);
    endfunction

    task automatic apply_regs();
        for (int i = 0; i < N; i++) begin
            req_reg[i*RW +: RW] = rg[i];
            req_wdata[i*W +: W] = wd[i];
        end
    endtask

    initial begin
        rg[0] = 5'd3;  rg[1] = 5'd7;  rg[2] = 5'd12; rg[3] = 5'd30;
        wd[0] = 64'h1111; wd[1] = 64'h2222;
        wd[2] = 64'h3333; wd[3] = 64'h4444;
        reset = 1'b0;
        req_vld = '0;
        req_we = '0;
        req_reg = '0;
        req_wdata = '0;
        bank_busy = 1'b0;
        bank_rsp_vld = 1'b0;
        bank_rsp_data = '0;
        drain = 1'b0;
        apply_regs();
        tick();
        tick();
        chk("rst_grant", req_grant, '0);
        chk("rst_rsp_vld", rsp_vld, '0);
        chk("rst_bank_vld", bank_req_vld, '0);
        chk("rst_bank_we", bank_we, '0);
        chk("rst_idle", idle, '0);
        chk("rst_err", err_unexp_rsp, '0);
        chk("rst_bank_reg", bank_reg, '0);
        chk("rst_rsp_data", rsp_data, '0);

        // round robin with a latency-2 bank
        reset = 1'b1;
        req_vld = '1;
        exp_g = 0;
        exp_r = 0;
        nrsp = 0;
        rsp_prev = 1'b0;
        for (int k = 0; k < 18; k++) begin
            tick();
            if (k < 12) begin
                chk("rr_grant", req_grant, oh(exp_g));
                chk("rr_bank_reg", bank_reg, rg[exp_g]);
                exp_g = (exp_g + 1) % N;
            end else begin
                chk("rr_grant_end", req_grant, '0);
            end
            if (rsp_prev) begin
                chk("rr_rsp_vld", rsp_vld, oh(exp_r));
                chk("rr_rsp_data", rsp_data[exp_r*W +: W], fdat(rg[exp_r]));
                exp_r = (exp_r + 1) % N;
                nrsp++;
            end else begin
                chk("rr_rsp_idle", rsp_vld, '0);
            end
            if (k == 11) req_vld = '0;
            if (bank_req_vld && !bank_we) begin
                reg_q.push_back(bank_reg);
                due_q.push_back(k + 2);
            end
            rsp_prev = 1'b0;
            bank_rsp_vld = 1'b0;
            if (due_q.size() > 0 && due_q[0] == k) begin
                bank_rsp_vld = 1'b1;
                bank_rsp_data = fdat(reg_q[0]);
                void'(due_q.pop_front());
                void'(reg_q.pop_front());
                rsp_prev = 1'b1;
            end
        end
        chk("rr_rsp_count", nrsp, 12);

        // read on 0 against write on 3
        req_we = 4'b1000;
        req_vld = 4'b1001;
        tick();
        chk("pri_grant1", req_grant, oh(FIRST));
        chk("pri_we1", bank_we, (FIRST == 3) ? 1 : 0);
        chk("pri_reg1", bank_reg, rg[FIRST]);
        req_vld[FIRST] = 1'b0;
        tick();
        chk("pri_grant2", req_grant, oh(SECOND));
        chk("pri_we2", bank_we, (SECOND == 3) ? 1 : 0);
        chk("pri_reg2", bank_reg, rg[SECOND]);
        chk("pri_wdata2", bank_wdata, wd[SECOND]);
        req_vld = '0;
        req_we = '0;
        tick();
        chk("pri_bank_off", bank_req_vld, '0);
        bank_rsp_vld = 1'b1;
        bank_rsp_data = 64'h0123_4567_89AB_CDEF;
        tick();
        chk("pri_rsp_vld", rsp_vld, oh(0));
        chk("pri_rsp_data", rsp_data[0 +: W], 64'h0123_4567_89AB_CDEF);

        // response with empty FIFO
        tick();
        chk("unexp_rsp_vld", rsp_vld, '0);
        chk("unexp_err", err_unexp_rsp, 1);
        bank_rsp_vld = 1'b0;
        tick();
        chk("unexp_sticky", err_unexp_rsp, 1);

        // bank stall with a write on requester 2
        rg[2] = 5'd5;
        wd[2] = 64'hDEAD;
        apply_regs();
        req_we = 4'b0100;
        req_vld = 4'b0100;
        bank_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_grant", req_grant, '0);
            chk("stall_bank_vld", bank_req_vld, '0);
        end
        bank_busy = 1'b0;
        tick();
        chk("stall_grant_after", req_grant, oh(2));
        chk("stall_we", bank_we, 1);
        chk("stall_reg", bank_reg, 5);
        chk("stall_wdata", bank_wdata, 64'hDEAD);
        req_vld = '0;
        req_we = '0;
        tick();
        chk("stall_bank_off", bank_req_vld, '0);

        // FIFO full, bank withholds responses
        req_vld = '1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("full_grant", req_grant, oh((3 + k) % N));
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("full_blocked", req_grant, '0);
        end
        bank_rsp_vld = 1'b1;
        bank_rsp_data = 64'hF1F0;
        tick();
        chk("full_pop_grant", req_grant, oh(3));
        chk("full_pop_rsp", rsp_vld, oh(3));
        chk("full_pop_data", rsp_data[3*W +: W], 64'hF1F0);
        req_vld = '0;

        // drain with two reads outstanding
        bank_rsp_data = 64'hA0;
        tick();
        chk("dr_rsp0", rsp_vld, oh(0));
        chk("dr_data0", rsp_data[0 +: W], 64'hA0);
        bank_rsp_data = 64'hB1;
        tick();
        chk("dr_rsp1", rsp_vld, oh(1));
        chk("dr_data1", rsp_data[1*W +: W], 64'hB1);
        bank_rsp_vld = 1'b0;
        drain = 1'b1;
        tick();
        chk("dr_idle_busy", idle, 0);
        req_vld = 4'b0001;
        tick();
        chk("dr_no_grant", req_grant, '0);
        tick();
        chk("dr_no_grant2", req_grant, '0);
        bank_rsp_vld = 1'b1;
        bank_rsp_data = 64'hC2;
        tick();
        chk("dr_rsp2", rsp_vld, oh(2));
        chk("dr_idle_one", idle, 0);
        bank_rsp_data = 64'hD3;
        tick();
        chk("dr_rsp3", rsp_vld, oh(3));
        chk("dr_data3", rsp_data[3*W +: W], 64'hD3);
        chk("dr_idle_rise", idle, 1);
        bank_rsp_vld = 1'b0;
        tick();
        chk("dr_idle_hold", idle, 1);
        chk("dr_no_grant3", req_grant, '0);
        drain = 1'b0;
        tick();
        chk("dr_exit_grant", req_grant, '0);
        chk("dr_exit_idle", idle, 0);
        tick();
        chk("dr_resume", req_grant, oh(0));
        req_vld = '0;
        bank_rsp_vld = 1'b1;
        bank_rsp_data = 64'hE4;
        tick();
        chk("dr_rsp_resume", rsp_vld, oh(0));
        chk("dr_data_resume", rsp_data[0 +: W], 64'hE4);
        bank_rsp_vld = 1'b0;

        // asynchronous reset mid-burst
        req_vld = '1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("ar_grant", req_grant, '0);
        chk("ar_bank_vld", bank_req_vld, '0);
        chk("ar_bank_we", bank_we, '0);
        chk("ar_bank_reg", bank_reg, '0);
        chk("ar_bank_wdata", bank_wdata, '0);
        chk("ar_rsp_vld", rsp_vld, '0);
        chk("ar_rsp_data", rsp_data, '0);
        chk("ar_err", err_unexp_rsp, '0);
        chk("ar_idle", idle, '0);
        req_vld = '0;
        tick();
        reset = 1'b1;
        bank_rsp_vld = 1'b1;
        bank_rsp_data = 64'h77;
        tick();
        chk("ar_late_rsp_vld", rsp_vld, '0);
        chk("ar_late_err", err_unexp_rsp, 1);
        bank_rsp_vld = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
